// File: rtl/pixel_write_arbiter_pkg.sv
// Purpose : shared screen geometry, pixel op codes and arbiter FSM encodings.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package screen_definitions;

   // Default number of rows; every row is 8 pixels wide.
   localparam int SCREEN_SIZE = 8;

   // Pixel operation codes presented on a_op / b_op.
   localparam logic [1:0] OP_SET = 2'b00;
   localparam logic [1:0] OP_CLR = 2'b01;
   localparam logic [1:0] OP_TGL = 2'b10;
   localparam logic [1:0] OP_CLS = 2'b11;

   // Read-modify-write sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_COMMIT = 2'd2,
      ST_SETTLE = 2'd3
   } state_t;

endpackage

// File: rtl/pixel_write_arbiter_apply.sv
// Purpose : combinational single-pixel modify of a whole image, plus row range check.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; result is valid whenever inputs are.
// Ports   : image_in (current image), x/y/op (pixel command),
//           next_image (modified image), out_of_range (y beyond last row on a pixel op).
module pixel_apply #(
   parameter int SCREEN_SIZE = 8,
   parameter int WIDTH       = SCREEN_SIZE * 8,
   parameter int YW          = (SCREEN_SIZE > 1) ? $clog2(SCREEN_SIZE) : 1
) (
   input  logic [WIDTH-1:0] image_in,
   input  logic [2:0]       x,
   input  logic [YW-1:0]    y,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] next_image,
   output logic             out_of_range
);
   import screen_definitions::*;

   // Row count held one bit wider than y so that a full power-of-two row count fits.
   localparam logic [YW:0] ROWS = SCREEN_SIZE[YW:0];

   logic [YW+2:0]    w_idx;
   logic [WIDTH-1:0] w_mask;

   // Bit index y*8+x is simply the concatenation {y, x}.
   assign w_idx  = {y, x};
   assign w_mask = {{(WIDTH-1){1'b0}}, 1'b1} << w_idx;

   // Clear-screen ignores the coordinates, so it can never be out of range.
   assign out_of_range = (op != OP_CLS) && ({1'b0, y} >= ROWS);

   always_comb begin
      next_image = image_in;
      case (op)
         OP_SET:  next_image = image_in | w_mask;
         OP_CLR:  next_image = image_in & ~w_mask;
         OP_TGL:  next_image = image_in ^ w_mask;
         OP_CLS:  next_image = '0;
         default: next_image = image_in;
      endcase
   end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Purpose : round-robin arbiter sequencing pixel read-modify-writes into the image register.
// Latency : valid sampled in cycle N, ack/draw high in N+2; one command per 4 cycles.
// Backpr. : requesters hold valid+operands until their one-cycle ack; loser waits <= 8 cycles.
// Ports   : clk/rst (sync, active-high); a_*/b_* requester command + ack/err;
//           image_in (image register readback); draw/draw_image (image register load).
module pixel_write_arbiter #(
   parameter int SCREEN_SIZE = screen_definitions::SCREEN_SIZE,
   parameter int WIDTH       = SCREEN_SIZE * 8,
   parameter int YW          = (SCREEN_SIZE > 1) ? $clog2(SCREEN_SIZE) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [2:0]       a_x,
   input  logic [YW-1:0]    a_y,
   input  logic [1:0]       a_op,
   output logic             a_ack,
   output logic             a_err,
   input  logic             b_valid,
   input  logic [2:0]       b_x,
   input  logic [YW-1:0]    b_y,
   input  logic [1:0]       b_op,
   output logic             b_ack,
   output logic             b_err,
   input  logic [WIDTH-1:0] image_in,
   output logic             draw,
   output logic [WIDTH-1:0] draw_image
);
   import screen_definitions::*;

   state_t           r_state;
   state_t           w_next_state;

   // Captured command of the current winner (id: 0 = A, 1 = B).
   logic [2:0]       r_x;
   logic [YW-1:0]    r_y;
   logic [1:0]       r_op;
   logic             r_id;
   // Tie-break pointer: set when B should win the next simultaneous request.
   logic             r_prefer_b;

   logic             r_draw;
   logic [WIDTH-1:0] r_draw_image;
   logic             r_a_ack;
   logic             r_a_err;
   logic             r_b_ack;
   logic             r_b_err;

   logic             w_grant_vld;
   logic             w_grant_b;
   logic [WIDTH-1:0] w_next_image;
   logic             w_oor;

   logic             w_draw_nxt;
   logic [WIDTH-1:0] w_draw_image_nxt;
   logic             w_a_ack_nxt;
   logic             w_a_err_nxt;
   logic             w_b_ack_nxt;
   logic             w_b_err_nxt;

   pixel_apply #(
      .SCREEN_SIZE (SCREEN_SIZE),
      .WIDTH       (WIDTH),
      .YW          (YW)
   ) u_apply (
      .image_in     (image_in),
      .x            (r_x),
      .y            (r_y),
      .op           (r_op),
      .next_image   (w_next_image),
      .out_of_range (w_oor)
   );

   // B wins when it is alone, or when both request and A was granted last.
   assign w_grant_vld = a_valid | b_valid;
   assign w_grant_b   = b_valid & (~a_valid | r_prefer_b);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: fixed 4-cycle walk once a command is accepted.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   w_next_state = w_grant_vld ? ST_APPLY : ST_IDLE;
         ST_APPLY:  w_next_state = ST_COMMIT;
         ST_COMMIT: w_next_state = ST_SETTLE;
         ST_SETTLE: w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // Output logic: next values of the output registers. Everything defaults to
   // low, so the pulse raised in APPLY falls again on the following edge.
   always_comb begin
      w_draw_nxt       = 1'b0;
      w_draw_image_nxt = r_draw_image;
      w_a_ack_nxt      = 1'b0;
      w_a_err_nxt      = 1'b0;
      w_b_ack_nxt      = 1'b0;
      w_b_err_nxt      = 1'b0;
      if (r_state == ST_APPLY) begin
         w_a_ack_nxt = ~r_id;
         w_b_ack_nxt = r_id;
         if (w_oor) begin
            w_a_err_nxt = ~r_id;
            w_b_err_nxt = r_id;
         end else begin
            w_draw_nxt       = 1'b1;
            w_draw_image_nxt = w_next_image;
         end
      end
   end

   // Command capture, pointer and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x          <= '0;
         r_y          <= '0;
         r_op         <= '0;
         r_id         <= 1'b0;
         r_prefer_b   <= 1'b0;
         r_draw       <= 1'b0;
         r_draw_image <= '0;
         r_a_ack      <= 1'b0;
         r_a_err      <= 1'b0;
         r_b_ack      <= 1'b0;
         r_b_err      <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && w_grant_vld) begin
            r_x        <= w_grant_b ? b_x  : a_x;
            r_y        <= w_grant_b ? b_y  : a_y;
            r_op       <= w_grant_b ? b_op : a_op;
            r_id       <= w_grant_b;
            r_prefer_b <= ~w_grant_b;
         end
         r_draw       <= w_draw_nxt;
         r_draw_image <= w_draw_image_nxt;
         r_a_ack      <= w_a_ack_nxt;
         r_a_err      <= w_a_err_nxt;
         r_b_ack      <= w_b_ack_nxt;
         r_b_err      <= w_b_err_nxt;
      end
   end

   assign draw       = r_draw;
   assign draw_image = r_draw_image;
   assign a_ack      = r_a_ack;
   assign a_err      = r_a_err;
   assign b_ack      = r_b_ack;
   assign b_err      = r_b_err;

endmodule
